// File: rtl/wb2axil_bridge.sv
// wb2axil_bridge: Wishbone classic slave port to AXI4-Lite master bridge.
// Ports: clk, rst (async, active-high); wb_* Wishbone side; m_axi_* AXI4-Lite side.
module wb2axil_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic to_hit;
    logic b_ok;
    logic r_ok;
    logic aw_done;
    logic w_done;

    assign to_hit  = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign b_ok    = (m_axi_bresp == 2'b00) || (m_axi_bresp == 2'b01);
    assign r_ok    = (m_axi_rresp == 2'b00) || (m_axi_rresp == 2'b01);
    // A channel is done once its valid is low or is accepted this cycle.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q || m_axi_wready;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rdat_d    = rdat_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d = wb_adr_i;
                    dat_d = wb_dat_i;
                    sel_d = wb_sel_i;
                    if (wb_we_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WADDR: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_WRESP;
                end
            end
            S_RADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RDATA;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    bready_d = 1'b0;
                    ack_d    = wb_cyc_i && b_ok;
                    err_d    = wb_cyc_i && !b_ok;
                    state_d  = S_RESP;
                end else if (to_hit) begin
                    err_d   = wb_cyc_i;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    rready_d = 1'b0;
                    rdat_d   = m_axi_rdata;
                    ack_d    = wb_cyc_i && r_ok;
                    err_d    = wb_cyc_i && !r_ok;
                    state_d  = S_RESP;
                end else if (to_hit) begin
                    err_d   = wb_cyc_i;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                // ack/err is high for this single cycle; stale stb is ignored.
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Late response is consumed and discarded.
                if ((bready_q && m_axi_bvalid) || (rready_q && m_axi_rvalid)) begin
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rdat_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rdat_q    <= rdat_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wb_dat_o      = rdat_q;
    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign m_axi_awaddr  = adr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = dat_q;
    assign m_axi_wstrb   = sel_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = adr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_wb2axil_bridge.sv
// tb_wb2axil_bridge: self-checking bench for wb2axil_bridge (TIMEOUT=8).
// Behavioural AXI4-Lite slave with per-channel delays; scoreboard of responses.
module tb_wb2axil_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_dat_o;
    logic        ack, err;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0;
    logic        wready = 1'b0;
    logic        arready = 1'b0;
    logic        bvalid = 1'b0;
    logic        rvalid = 1'b0;
    logic [1:0]  bresp = '0;
    logic [1:0]  rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    wb2axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_dat_o(wb_dat_o), .wb_ack_o(ack), .wb_err_o(err),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        chk;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    int aw_dly = 0, w_dly = 0, r_dly = 0;
    int aw_c = 0, w_c = 0, r_c = 0;
    logic [1:0]  bresp_v = '0, rresp_v = '0;
    logic [31:0] rdata_v = '0;

    // Slave: decide ready/valid at negedge for the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            aw_c = 0; w_c = 0; r_c = 0;
        end else begin
            awready = awvalid && (aw_c >= aw_dly);
            aw_c = !awvalid ? 0 : (awready ? aw_c : aw_c + 1);
            wready = wvalid && (w_c >= w_dly);
            w_c = !wvalid ? 0 : (wready ? w_c : w_c + 1);
            arready = arvalid;
            bvalid = bready;
            bresp = bresp_v;
            rvalid = rready && (r_c >= r_dly);
            r_c = !rready ? 0 : (rvalid ? r_c : r_c + 1);
            rdata = rdata_v;
            rresp = rresp_v;
        end
    end

    int cyc_n = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0;
    int aw_hi = 0, w_hi = 0, ack_n = 0, err_n = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
    logic [3:0]  s_seen = '0;

    // Monitor: pre-edge values at each rising edge.
    always @(posedge clk) begin
        cyc_n++;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (awvalid && awready) begin
            aw_hs++; aw_seen = awaddr; aw_hs_cyc = cyc_n;
        end
        if (wvalid && wready) begin
            w_hs++; w_seen = wdata; s_seen = wstrb; w_hs_cyc = cyc_n;
        end
        if (arvalid && arready) begin
            ar_hs++; ar_seen = araddr;
        end
        if (rvalid && rready) r_hs++;
        if (ack) ack_n++;
        if (err) err_n++;
    end

    task automatic xfer(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic hold, output int lat, output logic done);
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0; done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (ack || err) done = 1'b1;
        end
        if (!hold) begin
            wb_cyc = 1'b0; wb_stb = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({awvalid, wvalid, arvalid, bready, rready, ack, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected 0000000",
                     {awvalid, wvalid, arvalid, bready, rready, ack, err});
        end
        n_chk++;
        if (wb_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o);
        end
        n_chk++;
        if ({awaddr, wdata, wstrb, araddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h %h %h %h expected 0",
                     awaddr, wdata, wstrb, araddr);
        end
        n_chk++;
        if ({awprot, arprot} !== 6'b0) begin
            n_fail++; $display("FAIL prot: got %b expected 000000", {awprot, arprot});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat, a0, e0;
        logic done;
        exp_t e;
        aw_dly = 0; w_dly = 0; bresp_v = 2'b00;
        a0 = ack_n; e0 = err_n;
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        xfer(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL wr_done: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err}) begin
                n_fail++;
                $display("FAIL wr_resp: got ack=%b err=%b expected ack=%b err=%b",
                         ack, err, e.ack, e.err);
            end
        end
        n_chk++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL wr_lat: got %0d expected 3", lat);
        end
        n_chk++;
        if ({aw_seen, w_seen, s_seen} !== {32'h1000_0040, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL wr_fields: got %h %h %h expected 10000040 deadbeef f",
                     aw_seen, w_seen, s_seen);
        end
        n_chk++;
        if (aw_hs_cyc !== w_hs_cyc) begin
            n_fail++;
            $display("FAIL wr_same_cycle: got aw@%0d w@%0d expected equal",
                     aw_hs_cyc, w_hs_cyc);
        end
        @(negedge clk);
        n_chk++;
        if (ack !== 1'b0 || ack_n - a0 !== 1 || err_n - e0 !== 0) begin
            n_fail++;
            $display("FAIL wr_pulse: got acks=%0d errs=%0d expected 1 0",
                     ack_n - a0, err_n - e0);
        end
    endtask

    task automatic test_aw_delay();
        int lat, a0, ah0, wh0;
        logic done;
        exp_t e;
        aw_dly = 4; w_dly = 0; bresp_v = 2'b00;
        a0 = ack_n; ah0 = aw_hi; wh0 = w_hi;
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        xfer(1'b1, 32'h2000_0000, 32'h0102_0304, 4'h3, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL awd_done: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err}) begin
                n_fail++;
                $display("FAIL awd_resp: got ack=%b err=%b expected ack=%b err=%b",
                         ack, err, e.ack, e.err);
            end
        end
        n_chk++;
        if (aw_hi - ah0 !== 5 || w_hi - wh0 !== 1) begin
            n_fail++;
            $display("FAIL awd_valid_len: got aw=%0d w=%0d expected aw=5 w=1",
                     aw_hi - ah0, w_hi - wh0);
        end
        n_chk++;
        if (lat !== 7) begin
            n_fail++; $display("FAIL awd_lat: got %0d expected 7", lat);
        end
        @(negedge clk);
        n_chk++;
        if (ack_n - a0 !== 1) begin
            n_fail++; $display("FAIL awd_acks: got %0d expected 1", ack_n - a0);
        end
        aw_dly = 0;
    endtask

    task automatic test_read();
        int lat, e0;
        logic done;
        exp_t e;
        r_dly = 0; rdata_v = 32'h1234_5678; rresp_v = 2'b00;
        sb.push_back('{1'b1, 1'b0, 32'h1234_5678, 1'b1});
        xfer(1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL rd_done: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err} || (e.chk && wb_dat_o !== e.dat)) begin
                n_fail++;
                $display("FAIL rd_ok: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                         ack, err, wb_dat_o, e.ack, e.err, e.dat);
            end
        end
        n_chk++;
        if (lat !== 3 || ar_seen !== 32'h24) begin
            n_fail++;
            $display("FAIL rd_lat_addr: got lat=%0d addr=%h expected 3 00000024",
                     lat, ar_seen);
        end
        @(negedge clk);
        rdata_v = 32'hA5A5_0001; rresp_v = 2'b10;
        e0 = err_n;
        sb.push_back('{1'b0, 1'b1, 32'hA5A5_0001, 1'b1});
        xfer(1'b0, 32'h0000_0028, 32'h0, 4'hF, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL rd_err_done: got no response expected err");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err} || (e.chk && wb_dat_o !== e.dat)) begin
                n_fail++;
                $display("FAIL rd_slverr: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                         ack, err, wb_dat_o, e.ack, e.err, e.dat);
            end
        end
        @(negedge clk);
        n_chk++;
        if (err_n - e0 !== 1) begin
            n_fail++; $display("FAIL rd_err_pulse: got %0d expected 1", err_n - e0);
        end
        rresp_v = 2'b00;
    endtask

    task automatic test_timeout();
        int lat, n, r0;
        logic done, seen, early, drop, got;
        logic [31:0] dat_mid;
        exp_t e;
        r_dly = 20; rdata_v = 32'hBAD0_BAD0; rresp_v = 2'b00;
        sb.push_back('{1'b0, 1'b1, 32'hA5A5_0001, 1'b1});
        xfer(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL to_done: got no response expected err");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err} || (e.chk && wb_dat_o !== e.dat)) begin
                n_fail++;
                $display("FAIL to_err: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                         ack, err, wb_dat_o, e.ack, e.err, e.dat);
            end
        end
        n_chk++;
        if (lat !== 10 || rready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_lat: got lat=%0d rready=%b expected 10 1", lat, rready);
        end
        wb_adr = 32'h0000_0034; wb_we = 1'b0; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        r0 = r_hs; seen = 0; early = 0; drop = 0; got = 0; n = 0;
        dat_mid = '0;
        sb.push_back('{1'b1, 1'b0, 32'h0BEE_F00D, 1'b1});
        while (!got && n < 80) begin
            @(negedge clk);
            n++;
            if (!seen) begin
                if (arvalid) early = 1;
                if (r_hs != r0) begin
                    seen = 1; dat_mid = wb_dat_o;
                    r_dly = 0; rdata_v = 32'h0BEE_F00D;
                end else if (!rready) begin
                    drop = 1;
                end
            end else if (ack || err) begin
                got = 1;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        n_chk++;
        if (!seen || early || drop) begin
            n_fail++;
            $display("FAIL to_drain: got seen=%b early=%b drop=%b expected 1 0 0",
                     seen, early, drop);
        end
        n_chk++;
        if (dat_mid !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL to_dat_kept: got %h expected a5a50001", dat_mid);
        end
        n_chk++;
        if (!got) begin
            n_fail++; $display("FAIL to_next_done: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err} || (e.chk && wb_dat_o !== e.dat)) begin
                n_fail++;
                $display("FAIL to_next: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                         ack, err, wb_dat_o, e.ack, e.err, e.dat);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, a0, h0, c1;
        logic done;
        exp_t e;
        aw_dly = 0; w_dly = 0; bresp_v = 2'b00;
        a0 = ack_n; h0 = aw_hs;
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        xfer(1'b1, 32'h3000_0000, 32'h1111_1111, 4'hF, 1'b1, lat, done);
        c1 = aw_hs_cyc;
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL b2b_first: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err}) begin
                n_fail++;
                $display("FAIL b2b_resp1: got ack=%b err=%b expected ack=%b err=%b",
                         ack, err, e.ack, e.err);
            end
        end
        xfer(1'b1, 32'h3000_0004, 32'h2222_2222, 4'hC, 1'b0, lat, done);
        n_chk++;
        if (!done || sb.size() == 0) begin
            n_fail++; $display("FAIL b2b_second: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err}) begin
                n_fail++;
                $display("FAIL b2b_resp2: got ack=%b err=%b expected ack=%b err=%b",
                         ack, err, e.ack, e.err);
            end
        end
        n_chk++;
        if (lat !== 4 || aw_hs_cyc - c1 !== 4) begin
            n_fail++;
            $display("FAIL b2b_gap: got ack_gap=%0d aw_gap=%0d expected 4 4",
                     lat, aw_hs_cyc - c1);
        end
        @(negedge clk);
        n_chk++;
        if (aw_hs - h0 !== 2 || ack_n - a0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got aw=%0d acks=%0d expected 2 2",
                     aw_hs - h0, ack_n - a0);
        end
        n_chk++;
        if ({aw_seen, w_seen, s_seen} !== {32'h3000_0004, 32'h2222_2222, 4'hC}) begin
            n_fail++;
            $display("FAIL b2b_fields: got %h %h %h expected 30000004 22222222 c",
                     aw_seen, w_seen, s_seen);
        end
        n_chk++;
        if (wb_dat_o !== 32'h0BEE_F00D) begin
            n_fail++; $display("FAIL wr_dat_kept: got %h expected 0beef00d", wb_dat_o);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        logic done;
        exp_t e;
        aw_dly = 10; w_dly = 0;
        wb_adr = 32'h4000_0000; wb_dat = 32'h9999_9999; wb_sel = 4'hF;
        wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (awvalid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got awvalid=%b expected 1", awvalid);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({awvalid, wvalid, bready, ack, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected 00000",
                     {awvalid, wvalid, bready, ack, err});
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0; aw_dly = 0;
        @(negedge clk);
        sb.push_back('{1'b1, 1'b0, 32'h0, 1'b0});
        xfer(1'b1, 32'h4000_0010, 32'h55AA_55AA, 4'h0, 1'b0, lat, done);
        n_chk++;
        if (!done) begin
            n_fail++; $display("FAIL rst_after_done: got no response expected ack");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_chk++;
            if ({ack, err} !== {e.ack, e.err} || lat !== 3) begin
                n_fail++;
                $display("FAIL rst_after: got ack=%b err=%b lat=%0d expected ack=%b err=%b lat=3",
                         ack, err, lat, e.ack, e.err);
            end
        end
        n_chk++;
        if ({aw_seen, w_seen, s_seen} !== {32'h4000_0010, 32'h55AA_55AA, 4'h0}) begin
            n_fail++;
            $display("FAIL rst_after_fields: got %h %h %h expected 40000010 55aa55aa 0",
                     aw_seen, w_seen, s_seen);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_aw_delay();
        test_read();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
